// File: rtl/oflow_mem_buffer_pkg.sv
// Shared definitions for the oflow history frame buffer (write and read FSMs).
package oflow_mem_buffer_pkg;

    localparam int NUM_SLOTS             = 5;
    localparam int ADDR_WIDTH            = 6;
    localparam int TOTAL_FRAME_NUM_WIDTH = 8;
    localparam int SLOT_WIDTH            = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_COMMIT = 2'd2
    } write_state_t;

endpackage

// File: rtl/oflow_slot_ptr.sv
// Circular slot pointer plus saturating count of completed history frames.
// Both advance together on a single commit strobe.
module oflow_slot_ptr #(
    parameter int NUM_SLOTS  = 5,
    parameter int SLOT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  commit,
    output logic [SLOT_WIDTH-1:0] slot_ptr,
    output logic [SLOT_WIDTH-1:0] valid_history_frames
);

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(NUM_SLOTS - 1);
    localparam logic [SLOT_WIDTH-1:0] MAX_HIST  = SLOT_WIDTH'(NUM_SLOTS);

    // Advance the slot pointer (with wrap) and the history count (with saturation) on commit.
    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            slot_ptr             <= '0;
            valid_history_frames <= '0;
        end else if (commit) begin
            slot_ptr <= (slot_ptr == LAST_SLOT) ? '0 : slot_ptr + SLOT_WIDTH'(1);
            if (valid_history_frames != MAX_HIST) begin
                valid_history_frames <= valid_history_frames + SLOT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/oflow_fsm_write.sv
// Write-side controller of the oflow history frame buffer: picks a slot per
// frame, sequences bbox-pair line writes into it, and publishes per-slot end
// pointers plus the valid-history count for the read FSM.
module oflow_fsm_write #(
    parameter int NUM_SLOTS             = oflow_mem_buffer_pkg::NUM_SLOTS,
    parameter int ADDR_WIDTH            = oflow_mem_buffer_pkg::ADDR_WIDTH,
    parameter int TOTAL_FRAME_NUM_WIDTH = oflow_mem_buffer_pkg::TOTAL_FRAME_NUM_WIDTH,
    parameter int SLOT_WIDTH            = oflow_mem_buffer_pkg::SLOT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset_N,
    input  logic                                  start_write,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]      frame_num,
    input  logic [ADDR_WIDTH-1:0]                 num_of_bbox_in_frame,
    input  logic                                  bbox_valid,
    output logic                                  ready_for_bbox,
    output logic                                  we_0,
    output logic                                  we_1,
    output logic [ADDR_WIDTH-1:0]                 offset,
    output logic [SLOT_WIDTH-1:0]                 slot_to_write,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]      frame_to_write,
    output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]  end_pointers,
    output logic [SLOT_WIDTH-1:0]                 valid_history_frames,
    output logic                                  done_write
);

    import oflow_mem_buffer_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    write_state_t            state;
    write_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]   line_cnt;
    logic [SLOT_WIDTH-1:0]   slot_ptr;
    logic                    commit;

    oflow_slot_ptr #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_slot_ptr (
        .clk                  (clk),
        .reset_N              (reset_N),
        .commit               (commit),
        .slot_ptr             (slot_ptr),
        .valid_history_frames (valid_history_frames)
    );

    assign slot_to_write = slot_ptr;

    // State register, frame capture, line/remaining counters and per-slot end pointers.
    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            state          <= S_IDLE;
            remaining      <= '0;
            line_cnt       <= '0;
            frame_to_write <= '0;
            end_pointers   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_write) begin
                        frame_to_write         <= frame_num;
                        remaining              <= num_of_bbox_in_frame;
                        line_cnt               <= '0;
                        // Invalidate the slot about to be overwritten until it commits.
                        end_pointers[slot_ptr] <= '0;
                    end
                end
                S_WRITE: begin
                    if (bbox_valid) begin
                        line_cnt  <= line_cnt + ADDR_WIDTH'(1);
                        remaining <= (remaining >= TWO) ? remaining - TWO : '0;
                    end
                end
                S_COMMIT: begin
                    end_pointers[slot_ptr] <= line_cnt;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and combinational write-port / handshake outputs.
    always_comb begin
        state_nxt      = state;
        ready_for_bbox = 1'b0;
        we_0           = 1'b0;
        we_1           = 1'b0;
        offset         = '0;
        done_write     = 1'b0;
        commit         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_write) begin
                    state_nxt = (num_of_bbox_in_frame == '0) ? S_COMMIT : S_WRITE;
                end
            end
            S_WRITE: begin
                ready_for_bbox = 1'b1;
                we_0           = bbox_valid;
                // Odd half of the line exists only while at least two bboxes remain.
                we_1           = bbox_valid && (remaining >= TWO);
                offset         = line_cnt;
                if (bbox_valid && (remaining <= TWO)) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                done_write = 1'b1;
                commit     = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_oflow_fsm_write.sv
// Self-checking bench for oflow_fsm_write: directed frames plus randomized
// frames, checked against a frame-level model of slots and end pointers.
module tb_oflow_fsm_write;

    localparam int NS = 5;
    localparam int AW = 6;
    localparam int FW = 8;
    localparam int SW = 3;

    logic                    clk = 1'b0;
    logic                    reset_N = 1'b1;
    logic                    start_write = 1'b0;
    logic [FW-1:0]           frame_num = '0;
    logic [AW-1:0]           num_of_bbox_in_frame = '0;
    logic                    bbox_valid = 1'b0;
    logic                    ready_for_bbox;
    logic                    we_0;
    logic                    we_1;
    logic [AW-1:0]           offset;
    logic [SW-1:0]           slot_to_write;
    logic [FW-1:0]           frame_to_write;
    logic [NS-1:0][AW-1:0]   end_pointers;
    logic [SW-1:0]           valid_history_frames;
    logic                    done_write;

    int n_pass  = 0;
    int n_total = 0;

    // Frame-level reference model
    int exp_ep[NS];
    int exp_slot;
    int exp_hist;
    int exp_frame;

    always #5 clk = ~clk;

    oflow_fsm_write #(
        .NUM_SLOTS             (NS),
        .ADDR_WIDTH            (AW),
        .TOTAL_FRAME_NUM_WIDTH (FW),
        .SLOT_WIDTH            (SW)
    ) dut (
        .clk                  (clk),
        .reset_N              (reset_N),
        .start_write          (start_write),
        .frame_num            (frame_num),
        .num_of_bbox_in_frame (num_of_bbox_in_frame),
        .bbox_valid           (bbox_valid),
        .ready_for_bbox       (ready_for_bbox),
        .we_0                 (we_0),
        .we_1                 (we_1),
        .offset               (offset),
        .slot_to_write        (slot_to_write),
        .frame_to_write       (frame_to_write),
        .end_pointers         (end_pointers),
        .valid_history_frames (valid_history_frames),
        .done_write           (done_write)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) exp_ep[s] = 0;
        exp_slot  = 0;
        exp_hist  = 0;
        exp_frame = 0;
    endtask

    task automatic check_all_ep(input string tag);
        for (int s = 0; s < NS; s++) begin
            check($sformatf("%s_ep%0d", tag, s), 32'(end_pointers[s]), exp_ep[s]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_for_bbox), 0);
        check({tag, "_we0"},   32'(we_0), 0);
        check({tag, "_we1"},   32'(we_1), 0);
        check({tag, "_offset"}, 32'(offset), 0);
        check({tag, "_done"},  32'(done_write), 0);
        check({tag, "_slot"},  32'(slot_to_write), 0);
        check({tag, "_hist"},  32'(valid_history_frames), 0);
        check({tag, "_frame"}, 32'(frame_to_write), 0);
        check_all_ep(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_N     = 1'b1;
        start_write = 1'b0;
        bbox_valid  = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst");
        @(negedge clk);
        reset_N = 1'b0;
    endtask

    // mode 0: valid every cycle; 1: random valid; 2: valid held high throughout
    task automatic do_frame(input int fn, input int n, input int mode,
                            input bit restart, input bit start_in_commit);
        int   lines;
        int   k;
        int   cyc;
        logic v;
        lines = (n + 1) / 2;
        k     = 0;
        cyc   = 0;
        @(negedge clk);
        start_write          = 1'b1;
        frame_num            = FW'(fn);
        num_of_bbox_in_frame = AW'(n);
        bbox_valid           = (mode == 2);
        #1;
        check("idle_we0", 32'(we_0), 0);
        check("idle_ready", 32'(ready_for_bbox), 0);
        check("idle_done", 32'(done_write), 0);
        exp_frame = fn % 256;
        while (k < lines && cyc < 400) begin
            @(negedge clk);
            start_write          = restart && (cyc == 1);
            frame_num            = FW'($urandom);
            num_of_bbox_in_frame = AW'($urandom);
            v                    = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bbox_valid           = v;
            #1;
            if (cyc == 0) begin
                check("slot_cleared", 32'(end_pointers[exp_slot]), 0);
                check("slot_sel", 32'(slot_to_write), exp_slot);
                check("frame_cap", 32'(frame_to_write), exp_frame);
            end
            check("wr_ready", 32'(ready_for_bbox), 1);
            check("wr_we0", 32'(we_0), 32'(v));
            check("wr_we1", 32'(we_1), 32'(v && (n - 2 * k >= 2)));
            check("wr_offset", 32'(offset), k);
            check("wr_done", 32'(done_write), 0);
            if (v) k++;
            cyc++;
        end
        if (k < lines) check("line_timeout", k, lines);
        // Commit cycle
        @(negedge clk);
        start_write = start_in_commit;
        bbox_valid  = (mode == 2);
        #1;
        check("cm_done", 32'(done_write), 1);
        check("cm_ready", 32'(ready_for_bbox), 0);
        check("cm_we0", 32'(we_0), 0);
        check("cm_we1", 32'(we_1), 0);
        check("cm_offset", 32'(offset), 0);
        exp_ep[exp_slot] = lines;
        exp_slot         = (exp_slot + 1) % NS;
        if (exp_hist < NS) exp_hist++;
        // First cycle back in IDLE: published results visible
        @(negedge clk);
        start_write = 1'b0;
        #1;
        check("post_done", 32'(done_write), 0);
        check("post_ready", 32'(ready_for_bbox), 0);
        check("post_we0", 32'(we_0), 0);
        check("post_frame", 32'(frame_to_write), exp_frame);
        check("post_slot", 32'(slot_to_write), exp_slot);
        check("post_hist", 32'(valid_history_frames), exp_hist);
        check_all_ep("post");
        bbox_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        reset_N = 1'b0;

        // Basic even, odd and empty frames
        do_frame(12, 6, 0, 1'b0, 1'b0);
        do_frame(33, 5, 0, 1'b0, 1'b0);
        do_frame(44, 0, 0, 1'b0, 1'b0);

        // Seven back-to-back frames from a clean slot pointer
        do_reset();
        for (int i = 1; i <= 7; i++) do_frame(100 + i, 2 * i, 0, 1'b0, 1'b0);

        // Valid held high, start re-pulsed mid-frame and during commit
        do_frame(9, 9, 2, 1'b1, 1'b1);

        // Count boundaries
        do_frame(1, 63, 0, 1'b0, 1'b0);
        do_frame(2, 1, 0, 1'b0, 1'b0);

        // Randomized frames
        for (int i = 0; i < 15; i++) begin
            do_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), 1, 1'b0, 1'b0);
        end

        // Reset after two lines of a 10-bbox frame
        @(negedge clk);
        start_write          = 1'b1;
        frame_num            = FW'(77);
        num_of_bbox_in_frame = AW'(10);
        bbox_valid           = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start_write = 1'b0;
            bbox_valid  = 1'b1;
            #1;
            check("mid_offset", 32'(offset), i);
        end
        @(negedge clk);
        bbox_valid = 1'b1;
        #2;
        reset_N = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_N    = 1'b0;
        bbox_valid = 1'b0;
        do_frame(5, 3, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
